corescore_uart_tx: RTL

Byte-stream-to-UART transmitter for the CoreScore result path. Consumes the 8-bit valid/ready/last stream produced by the core-collection logic, buffers bytes in a small synchronous FIFO and serialises them as 8N1 frames on a single TX pin. Drop-in alternative to the ROM-backed output stage: it forwards whatever bytes the cores emit.

---
 rtl/corescore_uart_pkg.sv | 23 ++
 rtl/corescore_uart_fifo.sv | 53 +++++
 rtl/corescore_uart_tx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/corescore_uart_pkg.sv
// Shared types and helpers for the CoreScore UART transmitter: FSM encoding,
// end-of-line byte constants and the bit-period rounding function.
package corescore_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_EOL_CR = 3'd4,
        ST_EOL_LF = 3'd5
    } uart_state_t;

    localparam logic [7:0] CR_BYTE = 8'h0D;
    localparam logic [7:0] LF_BYTE = 8'h0A;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/corescore_uart_fifo.sv
// Synchronous FIFO, power-of-two depth, combinational read data at the head.
// Write is ignored when full, read ignored when empty; simultaneous rd/wr keeps count.
module corescore_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_vld && !empty;
    assign full   = (count == (AW + 1)'(DEPTH));
    assign empty  = (count == '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/corescore_uart_tx.sv
// Stream-to-UART 8N1 transmitter; byte accepted at edge N starts its frame after N+2,
// tready low only while FIFO is full or in reset. CORESCORE_UART_TX_EOL_EN appends CR/LF after tlast.
module corescore_uart_tx
    import corescore_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 16000000,
    parameter int unsigned BAUD       = 57600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tdata,
    input  logic       i_tlast,
    input  logic       i_tvalid,
    output logic       o_tready,
    output logic       o_uart_tx
);

    localparam int unsigned   DIV      = uart_div(CLK_FREQ, BAUD);
    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);
`ifdef CORESCORE_UART_TX_EOL_EN
    localparam int FW = 9;
`else
    localparam int FW = 8;
`endif

    uart_state_t   state_q;
    uart_state_t   state_d;
    logic [CW-1:0] cnt_q;
    logic          cnt_done;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          tx_d;
    logic          load_en;
    logic [7:0]    load_dat;

    logic [FW-1:0] fifo_wr_dat;
    logic [FW-1:0] fifo_rd_dat;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          accept;

    assign o_tready  = !fifo_full && !i_rst;
    assign accept    = i_tvalid && o_tready;
    assign o_uart_tx = tx_q;
    assign cnt_done  = (cnt_q == '0);

`ifdef CORESCORE_UART_TX_EOL_EN
    logic last_q;
    logic lf_pend_q;
    assign fifo_wr_dat = {i_tlast, i_tdata};
`else
    logic unused_tlast;
    assign unused_tlast = i_tlast;
    assign fifo_wr_dat  = i_tdata;
`endif

    corescore_uart_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (i_clk),
        .rst    (i_rst),
        .wr_vld (accept),
        .wr_dat (fifo_wr_dat),
        .rd_vld (fifo_pop),
        .rd_dat (fifo_rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        load_en  = 1'b0;
        load_dat = fifo_rd_dat[7:0];
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    load_en  = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START, ST_EOL_CR, ST_EOL_LF: begin
                if (cnt_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_done && bit_idx_q == 3'd7) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (cnt_done) begin
`ifdef CORESCORE_UART_TX_EOL_EN
                    if (last_q) begin
                        load_en  = 1'b1;
                        load_dat = CR_BYTE;
                        state_d  = ST_EOL_CR;
                    end else if (lf_pend_q) begin
                        load_en  = 1'b1;
                        load_dat = LF_BYTE;
                        state_d  = ST_EOL_LF;
                    end else
`endif
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        load_en  = 1'b1;
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // EOL states are start bits of the CR/LF frames, so they drive low too.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START, ST_EOL_CR, ST_EOL_LF: tx_d = 1'b0;
            ST_DATA:                        tx_d = shreg_q[0];
            default:                        tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_q      <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else begin
            tx_q <= tx_d;
            if (state_q == ST_IDLE || cnt_done) cnt_q <= CNT_LOAD;
            else                                cnt_q <= cnt_q - 1'b1;
            if (load_en)                              shreg_q <= load_dat;
            else if (state_q == ST_DATA && cnt_done) shreg_q <= shreg_q >> 1;
            if (state_q != ST_DATA) bit_idx_q <= '0;
            else if (cnt_done)      bit_idx_q <= bit_idx_q + 1'b1;
        end
    end

`ifdef CORESCORE_UART_TX_EOL_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q    <= 1'b0;
            lf_pend_q <= 1'b0;
        end else if (fifo_pop) begin
            last_q    <= fifo_rd_dat[8];
        end else if (state_q == ST_STOP && state_d == ST_EOL_CR) begin
            last_q    <= 1'b0;
            lf_pend_q <= 1'b1;
        end else if (state_q == ST_STOP && state_d == ST_EOL_LF) begin
            lf_pend_q <= 1'b0;
        end
    end
`endif

endmodule
